// File: rtl/swap_sched_pkg.sv
// Shared definitions for the swap scheduler: FSM state encoding, queued
// swap-request layout, swap sequence length and the port arbitration rule.
package swap_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    WR_A = 2'd2,
    WR_B = 2'd3
  } swap_state_e;

  // Register-file cycles spent on one swap with distinct addresses.
  localparam int unsigned SWAP_CYCLES     = 3;
  localparam int unsigned SWAP_ADDR_WIDTH = 7;

  // Default-width queue entry; the controller passes its own width-matched
  // entry type to the FIFO with the same field layout.
  typedef struct packed {
    logic [SWAP_ADDR_WIDTH-1:0] addr_a;
    logic [SWAP_ADDR_WIDTH-1:0] addr_b;
  } swap_entry_t;

  // Decide whether a queued swap wins the ports in IDLE.
  // With fair_mode clear the host always wins on contention; with it set the
  // winner alternates based on who won the previous grant.
  function automatic logic arb_pick_swap(
    input logic q_pending,
    input logic host_req,
    input logic fair_mode,
    input logic last_was_swap
  );
    logic pick;
    if (!q_pending) begin
      pick = 1'b0;
    end else if (!host_req) begin
      pick = 1'b1;
    end else if (fair_mode) begin
      pick = !last_was_swap;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/swap_req_fifo.sv
// Synchronous swap-request FIFO. Occupancy is tracked in a count register so
// full/empty are direct compares; push and pop may occur in the same cycle.
module swap_req_fifo
  import swap_sched_pkg::*;
#(
  parameter int unsigned QDEPTH  = 4,
  parameter type         entry_t = swap_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned     PTR_W     = $clog2(QDEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(QDEPTH);

  entry_t           mem_r [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/swap_sched_ctrl.sv
// Register-file port owner: queues A/B swap requests and executes each as a
// RD_A -> WR_A -> WR_B sequence, sharing the ports with host writes in IDLE.
// Build option: define SWAP_FAIR_ARB_EN for alternating swap/host arbitration
// on contention; without it host writes have strict priority.
module swap_sched_ctrl
  import swap_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr_w,
  input  logic [DATA_WIDTH-1:0] host_data_w,
  input  logic [ADDR_WIDTH-1:0] host_addr_r,
  output logic [DATA_WIDTH-1:0] host_data_r,
  output logic                  host_rd_valid,
  input  logic                  swap_valid,
  output logic                  swap_ready,
  input  logic [ADDR_WIDTH-1:0] swap_addr_a,
  input  logic [ADDR_WIDTH-1:0] swap_addr_b,
  output logic                  swap_done,
  output logic                  busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [ADDR_WIDTH-1:0] rf_addr_r,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  input  logic [DATA_WIDTH-1:0] rf_data_r
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
  } req_t;

  swap_state_e           state_r;
  swap_state_e           state_nxt_s;
  logic [DATA_WIDTH-1:0] temp_r;
  logic                  swap_done_r;
  logic                  done_nxt_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  pick_s;
  logic                  grant_swap_s;
  logic                  grant_host_s;
  logic                  same_addr_s;
  req_t                  push_entry_s;
  req_t                  head_s;

  assign swap_ready   = !full_s;
  assign push_s       = swap_valid && !full_s;
  assign push_entry_s = '{addr_a: swap_addr_a, addr_b: swap_addr_b};
  assign same_addr_s  = (head_s.addr_a == head_s.addr_b);
  assign host_data_r  = rf_data_r;
  assign busy         = (state_r != IDLE) || !empty_s;
  assign swap_done    = swap_done_r;

  swap_req_fifo #(
    .QDEPTH  (QDEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

`ifdef SWAP_FAIR_ARB_EN
  logic last_swap_r;

  // Remember the last arbitration winner so contended grants alternate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_swap_r <= 1'b0;
    end else if (grant_swap_s) begin
      last_swap_r <= 1'b1;
    end else if (grant_host_s) begin
      last_swap_r <= 1'b0;
    end
  end

  assign pick_s = arb_pick_swap(!empty_s, host_wr_valid, 1'b1, last_swap_r);
`else
  assign pick_s = arb_pick_swap(!empty_s, host_wr_valid, 1'b0, 1'b0);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture A's old value during RD_A and register the completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_r      <= '0;
      swap_done_r <= 1'b0;
    end else begin
      if (state_r == RD_A) begin
        temp_r <= rf_data_r;
      end
      swap_done_r <= done_nxt_s;
    end
  end

  // Next-state and register-file port steering; only one owner per cycle.
  always_comb begin
    state_nxt_s   = state_r;
    rf_we         = 1'b0;
    rf_addr_w     = host_addr_w;
    rf_data_w     = host_data_w;
    rf_addr_r     = host_addr_r;
    host_wr_ready = 1'b0;
    host_rd_valid = 1'b0;
    pop_s         = 1'b0;
    done_nxt_s    = 1'b0;
    grant_swap_s  = 1'b0;
    grant_host_s  = 1'b0;
    case (state_r)
      IDLE: begin
        host_rd_valid = 1'b1;
        grant_swap_s  = pick_s;
        grant_host_s  = host_wr_valid && !pick_s;
        if (grant_swap_s) begin
          if (same_addr_s) begin
            // Swapping a location with itself is a no-op: retire it at once.
            pop_s      = 1'b1;
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = RD_A;
          end
        end else if (grant_host_s) begin
          host_wr_ready = 1'b1;
          rf_we         = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_A: begin
        rf_addr_r   = head_s.addr_a;
        state_nxt_s = WR_A;
      end
      WR_A: begin
        rf_addr_r   = head_s.addr_b;
        rf_we       = 1'b1;
        rf_addr_w   = head_s.addr_a;
        rf_data_w   = rf_data_r;
        state_nxt_s = WR_B;
      end
      WR_B: begin
        rf_we       = 1'b1;
        rf_addr_w   = head_s.addr_b;
        rf_data_w   = temp_r;
        pop_s       = 1'b1;
        done_nxt_s  = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_swap_sched_ctrl.sv
// Bench for swap_sched_ctrl: a register-file model on the rf ports, a
// transaction-level reference model checked every cycle, and directed tests
// with literal expectations.
module tb_swap_sched_ctrl;
  import swap_sched_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int QD = 4;
  localparam int NW = 2 ** AW;
`ifdef SWAP_FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_addr_w;
  logic [DW-1:0] host_data_w;
  logic [AW-1:0] host_addr_r;
  logic [DW-1:0] host_data_r;
  logic          host_rd_valid;
  logic          swap_valid;
  logic          swap_ready;
  logic [AW-1:0] swap_addr_a;
  logic [AW-1:0] swap_addr_b;
  logic          swap_done;
  logic          busy;
  logic          rf_we;
  logic [AW-1:0] rf_addr_w;
  logic [AW-1:0] rf_addr_r;
  logic [DW-1:0] rf_data_w;
  logic [DW-1:0] rf_data_r;

  swap_sched_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QDEPTH(QD)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_addr_w(host_addr_w), .host_data_w(host_data_w),
    .host_addr_r(host_addr_r), .host_data_r(host_data_r),
    .host_rd_valid(host_rd_valid),
    .swap_valid(swap_valid), .swap_ready(swap_ready),
    .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b),
    .swap_done(swap_done), .busy(busy),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_addr_r(rf_addr_r),
    .rf_data_w(rf_data_w), .rf_data_r(rf_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file attached to the controller, with a bench preload port.
  logic [DW-1:0] rf_mem [NW];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (rf_we) rf_mem[rf_addr_w] <= rf_data_w;
  end
  assign rf_data_r = rf_mem[rf_addr_r];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [AW-1:0] a; logic [AW-1:0] b; } pair_t;
  pair_t         m_q[$];
  logic [DW-1:0] m_mem [NW];
  bit            m_valid [NW];
  int            m_phase = 0;   // 0: idle, 1..SWAP_CYCLES: cycle within a swap
  bit            m_last  = 1'b0;
  bit            m_done  = 1'b0;

  function automatic bit m_pick();
    if (m_q.size() == 0) return 1'b0;
    if (!host_wr_valid) return 1'b1;
    return FAIR && !m_last;
  endfunction

  initial forever begin : model
    bit can_push;
    bit nd;
    logic [DW-1:0] t;
    pair_t hd;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      // Reset after the A write leaves A holding B's old value.
      if (m_phase == SWAP_CYCLES && m_q.size() > 0) begin
        hd = m_q[0];
        m_mem[hd.a] = m_mem[hd.b];
      end
      m_q.delete();
      m_phase = 0;
      m_last  = 1'b0;
      m_done  = 1'b0;
    end else begin
      can_push = (m_q.size() < QD);
      nd = 1'b0;
      if (m_phase == 0) begin
        if (m_pick()) begin
          m_last = 1'b1;
          if (m_q[0].a == m_q[0].b) begin
            void'(m_q.pop_front());
            nd = 1'b1;
          end else begin
            m_phase = 1;
          end
        end else if (host_wr_valid) begin
          m_mem[host_addr_w]   = host_data_w;
          m_valid[host_addr_w] = 1'b1;
          m_last = 1'b0;
        end
      end else if (m_phase == SWAP_CYCLES) begin
        hd = m_q.pop_front();
        t = m_mem[hd.a];
        m_mem[hd.a] = m_mem[hd.b];
        m_mem[hd.b] = t;
        m_phase = 0;
        nd = 1'b1;
      end else begin
        m_phase++;
      end
      if (swap_valid && can_push) m_q.push_back('{a: swap_addr_a, b: swap_addr_b});
      if (pre_we) begin
        m_mem[pre_addr]   = pre_data;
        m_valid[pre_addr] = 1'b1;
      end
      m_done = nd;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin : cmp
    bit idle;
    bit hwr;
    @(negedge clk);
    idle = (m_phase == 0);
    hwr  = idle && host_wr_valid && !m_pick();
    chk("swap_ready", 32'(swap_ready), 32'(m_q.size() < QD));
    chk("busy", 32'(busy), 32'(!idle || m_q.size() > 0));
    chk("swap_done", 32'(swap_done), 32'(m_done));
    chk("host_rd_valid", 32'(host_rd_valid), 32'(idle));
    chk("host_wr_ready", 32'(host_wr_ready), 32'(hwr));
    chk("rf_we", 32'(rf_we), 32'(hwr || m_phase == 2 || m_phase == 3));
    if (idle && m_valid[host_addr_r])
      chk("host_data_r", 32'(host_data_r), 32'(m_mem[host_addr_r]));
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [DW-1:0] pdat(input int i);
    logic [31:0] v;
    case (i)
      3:       v = 32'hAA;
      9:       v = 32'h55;
      5:       v = 32'h12;
      default: v = i * 37 + 11;
    endcase
    return v[DW-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    bit saw;
    int stamps[$];
    int grants[$];
    reset_n = 1'b0; host_wr_valid = 1'b0; host_addr_w = '0; host_data_w = '0;
    host_addr_r = '0; swap_valid = 1'b0; swap_addr_a = '0; swap_addr_b = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    tick(3);
    chk("rst_swap_ready", 32'(swap_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(host_rd_valid), 32'd1);
    chk("rst_wr_ready", 32'(host_wr_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(swap_done), 32'd0);
    reset_n = 1'b1;
    tick(1);

    for (int i = 0; i < NW; i++) begin
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = pdat(i);
      tick(1);
    end
    pre_we = 1'b0;

    // Host read in IDLE
    host_addr_r = 7'd9; #1;
    chk("rd_mem9", 32'(host_data_r), 32'h55);
    chk("rd_valid_idle", 32'(host_rd_valid), 32'd1);

    // Basic swap (3,9)
    swap_valid = 1'b1; swap_addr_a = 7'd3; swap_addr_b = 7'd9;
    tick(1);
    swap_valid = 1'b0;
    lat = 0;
    while (swap_done !== 1'b1 && lat < 12) begin
      tick(1); lat++;
      if (lat <= 3) chk("rd_valid_busy", 32'(host_rd_valid), 32'd0);
    end
    chk("lat_basic", 32'(lat), 32'd4);
    host_addr_r = 7'd3; #1;
    chk("swap_mem3", 32'(host_data_r), 32'h55);
    host_addr_r = 7'd9; #1;
    chk("swap_mem9", 32'(host_data_r), 32'hAA);

    // Same-address swap (5,5)
    swap_valid = 1'b1; swap_addr_a = 7'd5; swap_addr_b = 7'd5;
    tick(1);
    swap_valid = 1'b0;
    lat = 0; saw = 1'b0;
    while (swap_done !== 1'b1 && lat < 12) begin
      if (rf_we) saw = 1'b1;
      tick(1); lat++;
    end
    chk("lat_same", 32'(lat), 32'd1);
    chk("same_no_we", 32'(saw), 32'd0);
    host_addr_r = 7'd5; #1;
    chk("same_mem5", 32'(host_data_r), 32'h12);
    tick(2);

`ifndef SWAP_FAIR_ARB_EN
    // Queue fills while the host holds the ports
    host_wr_valid = 1'b1; host_addr_w = 7'd100;
    for (int k = 0; k < 4; k++) begin
      swap_valid = 1'b1;
      swap_addr_a = AW'(10 + 2 * k); swap_addr_b = AW'(11 + 2 * k);
      host_data_w = DW'(32'h40 + k);
      tick(1);
    end
    swap_valid = 1'b0;
    chk("full_ready", 32'(swap_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_host_ready", 32'(host_wr_ready), 32'd1);
    tick(3);
    chk("no_start", 32'(host_rd_valid), 32'd1);
    chk("no_done", 32'(swap_done), 32'd0);
    host_wr_valid = 1'b0;
    for (int c = 1; c <= 40 && stamps.size() < 4; c++) begin
      tick(1);
      if (swap_done) stamps.push_back(c);
    end
    chk("n_done", 32'(stamps.size()), 32'd4);
    for (int k = 1; k < stamps.size(); k++)
      chk("done_gap", 32'(stamps[k] - stamps[k-1]), 32'd4);
    host_addr_r = 7'd100; #1;
    chk("host_wr_mem100", 32'(host_data_r), 32'h43);
`else
    // Contention: two queued swaps against a held host write
    host_wr_valid = 1'b1; host_addr_w = 7'd100; host_data_w = 8'h77;
    tick(1);
    swap_valid = 1'b1; swap_addr_a = 7'd20; swap_addr_b = 7'd21;
    tick(1);
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      if (host_rd_valid && host_wr_ready) grants.push_back(2);
      else if (host_rd_valid && busy) grants.push_back(1);
      if (c == 0) begin swap_addr_a = 7'd22; swap_addr_b = 7'd23; end
      else swap_valid = 1'b0;
      tick(1);
    end
    swap_valid = 1'b0;
    chk("n_grants", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++)
      chk("grant_order", 32'(grants[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    host_wr_valid = 1'b0;
    for (int c = 0; c < 20 && busy; c++) tick(1);
    host_addr_r = 7'd20; #1;
    chk("fair_mem20", 32'(host_data_r), 32'(pdat(21)));
`endif
    tick(2);
    chk("idle_before_rst", 32'(busy), 32'd0);

    // Reset during WR_B
    swap_valid = 1'b1; swap_addr_a = 7'd30; swap_addr_b = 7'd31;
    tick(1);
    swap_valid = 1'b0;
    tick(3);
    chk("in_wr_b_we", 32'(rf_we), 32'd1);
    reset_n = 1'b0; #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(swap_ready), 32'd1);
    chk("rst_mid_we", 32'(rf_we), 32'd0);
    saw = 1'b0;
    repeat (2) begin tick(1); if (swap_done) saw = 1'b1; end
    reset_n = 1'b1;
    repeat (3) begin tick(1); if (swap_done) saw = 1'b1; end
    chk("rst_mid_no_done", 32'(saw), 32'd0);
    host_addr_r = 7'd30; #1;
    chk("rst_mid_mem30", 32'(host_data_r), 32'(pdat(31)));
    host_addr_r = 7'd31; #1;
    chk("rst_mid_mem31", 32'(host_data_r), 32'(pdat(31)));

    // Whole register file against the model
    for (int i = 0; i < NW; i++)
      if (m_valid[i]) chk("mem_final", 32'(rf_mem[i]), 32'(m_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
